clearable_memory: RTL and testbench
===================================

# clearable_memory

Parametrised single-port synchronous RAM, successor to the fixed 512×8 `memory` block: configurable width and depth, per-byte write enables, registered read with a `valid` strobe, an out-of-range error flag, and a built-in clear engine that zeroes every location in hardware. Used wherever a scratch buffer must start from, or return to, a known all-zero state without a software sweep.

## Interface
- `data_width`, 16, word width in bits; must be a multiple of 8
- `mem_size`, 512, number of words; need not be a power of two
- `addr_width`, 9, address bits; must be ≥ $clog2(mem_size)
- `init_on_reset`, 1, if 1 the block runs a full clear after reset
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `read`  in  1  read request, sampled each edge
- `write`  in  1  write request, sampled each edge
- `addr`  in  addr_width  word address
- `data_in`  in  data_width  write data
- `byte_en`  in  data_width/8  per-byte write enable; bit i covers data_in[8i+7:8i]
- `clear`  in  1  single-cycle request to zero all locations
- `data_out`  out  data_width  registered read data
- `valid`  out  1  data_out updated this cycle
- `err`  out  1  one-cycle flag: last accepted request had addr ≥ mem_size
- `busy`  out  1  clear engine running; requests ignored

## Operation
- FSM states: IDLE, CLEAR. `busy` = (state == CLEAR).
- Reset: state ← CLEAR if init_on_reset, else IDLE; clear counter ← 0; data_out ← 0, valid ← 0, err ← 0. Memory contents are not touched by reset itself.
- CLEAR: writes all-zero to mem[cnt], then cnt++; after writing mem_size−1, state ← IDLE. Exactly mem_size cycles.
- IDLE + clear: state ← CLEAR, cnt ← 0. Any read/write that cycle is dropped.
- CLEAR + clear: counter restarts at 0.
- Reset mid-clear: aborts; restarts from 0 if init_on_reset, else IDLE with partial contents.
- Requests while busy: dropped, not queued; valid and err stay 0.
- Write (IDLE, addr < mem_size): bytes with byte_en=1 updated; others retained. byte_en = 0 is a legal no-op.
- Read (IDLE, addr < mem_size): data_out ← mem[addr], valid ← 1.
- Read + write, same address, same cycle: read-before-write; data_out returns old contents, new data is visible from the next read.
- Out-of-range (addr ≥ mem_size): write is suppressed; a read gives data_out ← 0, valid ← 1; err ← 1 in both cases.
- With no read accepted: data_out holds its last value; valid ← 0.

## Timing
- Read latency 1: request at edge N, data_out/valid/err valid after edge N+1. One read per cycle, back-to-back, no bubbles.
- Write takes effect at the sampling edge. Readable at N+1 (issue read at N+1, data after N+2).
- busy rises the cycle after clear is sampled (or in reset if init_on_reset) and stays high for mem_size cycles. The first accepted request is on the edge where busy is observed 0.
- valid and err are single-cycle pulses unless requests continue.

## Structure
- Package `memory_pkg`: typedef enum `mem_state_t` {MEM_IDLE, MEM_CLEAR}; a function returning $clog2 for checking addr_width.
- Elaboration-time assertions: data_width % 8 == 0; 2**addr_width ≥ mem_size.
- Sub-module `mem_clear_seq`: owns the FSM and address counter. Outputs busy, clr_we, clr_addr. Storage array, byte-lane mux and read register stay in the top.

## Test plan
- Reset with init_on_reset=1, mem_size=512 → busy is high for exactly 512 cycles; then reading 0..511 returns 0 for every word, with valid one cycle after each read.
- Write addr k, data k[15:0], byte_en=2'b11, for k = 0..511; read back → data_out == k on every read, err = 0.
- Write 16'hAAAA to addr 5, then 16'h1234 with byte_en=2'b01 → read returns 16'hAA34. Read and write 16'h5555 to addr 5 in the same cycle → data_out = 16'hAA34; the next read = 16'h5555.
- With mem_size=500 and addr_width=9: write to addr 505 → err = 1 and no write; read addr 505 → data_out = 0, valid = 1, err = 1.
- Pulse clear after filling memory; issue write to addr 3 while busy → write dropped; after the clear completes, addr 3 reads 0. Pulse clear again mid-clear → busy lasts mem_size cycles from the second pulse.
- Assert rst for 1 cycle at clear cycle 100 with init_on_reset=0 → busy = 0 immediately; addr 0..99 read 0; addr 200 keeps its pre-clear value.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and helpers for the clearable scratch RAM.
package memory_pkg;

  typedef enum logic [0:0] {
    MEM_IDLE  = 1'b0,
    MEM_CLEAR = 1'b1
  } mem_state_t;

  // Address bits needed to index n words (at least one).
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Clear engine: walks every word address once, driving a zero-write strobe.
module mem_clear_seq
  import memory_pkg::*;
#(
  parameter int mem_size      = 512,
  parameter int addr_width    = 9,
  parameter bit init_on_reset = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  busy,
  output logic                  clr_we,
  output logic [addr_width-1:0] clr_addr
);

  localparam logic [addr_width-1:0] last_addr = addr_width'(mem_size - 1);
  localparam logic [addr_width-1:0] one_addr  = addr_width'(1'b1);
  localparam logic [addr_width-1:0] zero_addr = {addr_width{1'b0}};

  mem_state_t            state;
  logic [addr_width-1:0] cnt;

  // State and sweep counter; a new clear request restarts the sweep from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= init_on_reset ? MEM_CLEAR : MEM_IDLE;
      cnt   <= zero_addr;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (clear) begin
            state <= MEM_CLEAR;
          end
          cnt <= zero_addr;
        end
        MEM_CLEAR: begin
          if (clear) begin
            cnt <= zero_addr;
          end else if (cnt == last_addr) begin
            state <= MEM_IDLE;
            cnt   <= zero_addr;
          end else begin
            cnt <= cnt + one_addr;
          end
        end
        default: begin
          state <= MEM_IDLE;
          cnt   <= zero_addr;
        end
      endcase
    end
  end

  // A reset edge aborts the sweep without zeroing the current word.
  assign busy     = (state == MEM_CLEAR);
  assign clr_we   = busy && !rst;
  assign clr_addr = cnt;

endmodule

// File: rtl/clearable_memory.sv
// Single-port RAM with byte enables, registered read, range error and hardware clear.
module clearable_memory
  import memory_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int mem_size      = 512,
  parameter int addr_width    = 9,
  parameter bit init_on_reset = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read,
  input  logic                    write,
  input  logic [addr_width-1:0]   addr,
  input  logic [data_width-1:0]   data_in,
  input  logic [data_width/8-1:0] byte_en,
  input  logic                    clear,
  output logic [data_width-1:0]   data_out,
  output logic                    valid,
  output logic                    err,
  output logic                    busy
);

  localparam int lanes     = data_width / 8;
  localparam int idx_width = addr_bits(mem_size);
  localparam logic [addr_width:0]   addr_limit = (addr_width + 1)'(mem_size);
  localparam logic [data_width-1:0] zero_word  = {data_width{1'b0}};

  if (data_width % 8 != 0) begin : g_bad_width
    $error("clearable_memory: data_width must be a multiple of 8");
  end
  if (addr_width < addr_bits(mem_size)) begin : g_bad_addr
    $error("clearable_memory: addr_width too small for mem_size");
  end

  logic [data_width-1:0] mem [mem_size];

  logic                  clr_we;
  logic [addr_width-1:0] clr_addr;
  logic                  accept;
  logic                  in_range;
  logic [idx_width-1:0]  idx;
  logic [idx_width-1:0]  clr_idx;

  mem_clear_seq #(
    .mem_size      (mem_size),
    .addr_width    (addr_width),
    .init_on_reset (init_on_reset)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Request qualification: a clear request swallows any access in the same cycle.
  always_comb begin
    accept   = !busy && !clear;
    in_range = ({1'b0, addr} < addr_limit);
    idx      = addr[idx_width-1:0];
    clr_idx  = clr_addr[idx_width-1:0];
  end

  // Storage: clear sweep has priority, otherwise byte-lane writes in range.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= zero_word;
    end else if (accept && write && in_range) begin
      for (int i = 0; i < lanes; i++) begin
        if (byte_en[i]) begin
          mem[idx][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // Read register and status strobes; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= zero_word;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= accept && read;
      err   <= accept && (read || write) && !in_range;
      if (accept && read) begin
        data_out <= in_range ? mem[idx] : zero_word;
      end
    end
  end

endmodule

// File: tb/tb_clearable_memory.sv
// Scoreboard bench: a 512-word auto-clearing instance and a 500-word manual one.
module tb_clearable_memory;

  typedef struct {
    logic        vld;
    logic        err;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, read_a, write_a, clear_a;
  logic        rst_b, read_b, write_b, clear_b;
  logic [8:0]  addr;
  logic [15:0] data_in;
  logic [1:0]  byte_en;
  logic [15:0] data_out_a, data_out_b;
  logic        valid_a, err_a, busy_a;
  logic        valid_b, err_b, busy_b;

  logic [15:0] mdl_a [512];
  logic [15:0] mdl_b [500];
  exp_t        sb [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  clearable_memory #(
    .data_width(16), .mem_size(512), .addr_width(9), .init_on_reset(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .read(read_a), .write(write_a), .addr(addr),
    .data_in(data_in), .byte_en(byte_en), .clear(clear_a),
    .data_out(data_out_a), .valid(valid_a), .err(err_a), .busy(busy_a)
  );

  clearable_memory #(
    .data_width(16), .mem_size(500), .addr_width(9), .init_on_reset(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .read(read_b), .write(write_b), .addr(addr),
    .data_in(data_in), .byte_en(byte_en), .clear(clear_b),
    .data_out(data_out_b), .valid(valid_b), .err(err_b), .busy(busy_b)
  );

  // One request cycle on instance sel; acc says whether the bench expects it accepted.
  task automatic op(input bit sel, input bit rd, input bit wr, input int a,
                    input logic [15:0] d, input logic [1:0] be, input bit acc);
    exp_t        e;
    exp_t        got;
    int          size;
    logic [15:0] m;
    size    = sel ? 500 : 512;
    addr    = a[8:0];
    data_in = d;
    byte_en = be;
    if (sel) begin read_b = rd; write_b = wr; end
    else     begin read_a = rd; write_a = wr; end
    if (acc && (rd || wr)) begin
      e.vld  = rd;
      e.err  = (a >= size);
      e.data = 16'h0000;
      if (a < size) e.data = sel ? mdl_b[a] : mdl_a[a];
      sb.push_back(e);
      if (wr && a < size) begin
        m = sel ? mdl_b[a] : mdl_a[a];
        for (int i = 0; i < 2; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
        if (sel) mdl_b[a] = m; else mdl_a[a] = m;
      end
    end
    @(posedge clk); #1;
    read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
    got.vld  = sel ? valid_b : valid_a;
    got.err  = sel ? err_b : err_a;
    got.data = sel ? data_out_b : data_out_a;
    n_cmp++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got.vld !== e.vld || got.err !== e.err || (e.vld && got.data !== e.data)) begin
        n_fail++;
        $display("FAIL access[%0d] addr=%0d: got valid=%b err=%b data=%h, want valid=%b err=%b data=%h",
                 sel, a, got.vld, got.err, got.data, e.vld, e.err, e.data);
      end
    end else if (got.vld !== 1'b0 || got.err !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped[%0d] addr=%0d: got valid=%b err=%b, want valid=0 err=0",
               sel, a, got.vld, got.err);
    end
  endtask

  // Clear request with a read in the same cycle; the read must vanish and busy rise.
  task automatic pulse_clear(input bit sel);
    addr = 9'd7;
    if (sel) begin clear_b = 1'b1; read_b = 1'b1; end
    else     begin clear_a = 1'b1; read_a = 1'b1; end
    @(posedge clk); #1;
    clear_a = 1'b0; read_a = 1'b0; clear_b = 1'b0; read_b = 1'b0;
    n_cmp++;
    if ((sel ? valid_b : valid_a) !== 1'b0 || (sel ? busy_b : busy_a) !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pulse[%0d]: got valid=%b busy=%b, want valid=0 busy=1",
               sel, sel ? valid_b : valid_a, sel ? busy_b : busy_a);
    end
  endtask

  task automatic count_busy_a(input string tag);
    int n = 0;
    while (busy_a === 1'b1 && n < 2000) begin
      n++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n != 512) begin
      n_fail++;
      $display("FAIL %s: busy lasted %0d cycles, want 512", tag, n);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    n_cmp++;
    if (data_out_a !== 16'h0000 || valid_a !== 1'b0 || err_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: got data=%h valid=%b err=%b busy=%b, want 0000 0 0 1",
               data_out_a, valid_a, err_a, busy_a);
    end
    n_cmp++;
    if (data_out_b !== 16'h0000 || valid_b !== 1'b0 || err_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: got data=%h valid=%b err=%b busy=%b, want 0000 0 0 0",
               data_out_b, valid_b, err_b, busy_b);
    end
    count_busy_a("init_clear");
    for (int k = 0; k < 512; k++) mdl_a[k] = 16'h0000;
    for (int k = 0; k < 512; k++) op(1'b0, 1'b1, 1'b0, k, 16'h0000, 2'b00, 1'b1);
  endtask

  task automatic test_fill();
    for (int k = 0; k < 512; k++) op(1'b0, 1'b0, 1'b1, k, k[15:0], 2'b11, 1'b1);
    for (int k = 0; k < 512; k++) op(1'b0, 1'b1, 1'b0, k, 16'h0000, 2'b00, 1'b1);
  endtask

  task automatic test_byte_en();
    op(1'b0, 1'b0, 1'b1, 5, 16'hAAAA, 2'b11, 1'b1);
    op(1'b0, 1'b0, 1'b1, 5, 16'h1234, 2'b01, 1'b1);
    op(1'b0, 1'b1, 1'b0, 5, 16'h0000, 2'b00, 1'b1);
    op(1'b0, 1'b1, 1'b1, 5, 16'h5555, 2'b11, 1'b1);
    op(1'b0, 1'b1, 1'b0, 5, 16'h0000, 2'b00, 1'b1);
    op(1'b0, 1'b0, 1'b1, 5, 16'hFFFF, 2'b00, 1'b1);
    op(1'b0, 1'b0, 1'b1, 6, 16'hC3C3, 2'b10, 1'b1);
    op(1'b0, 1'b1, 1'b0, 5, 16'h0000, 2'b00, 1'b1);
    op(1'b0, 1'b1, 1'b0, 6, 16'h0000, 2'b00, 1'b1);
  endtask

  task automatic test_clear();
    pulse_clear(1'b0);
    op(1'b0, 1'b0, 1'b1, 3, 16'h7777, 2'b11, 1'b0);
    op(1'b0, 1'b1, 1'b0, 3, 16'h0000, 2'b00, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    pulse_clear(1'b0);
    count_busy_a("restarted_clear");
    for (int k = 0; k < 512; k++) mdl_a[k] = 16'h0000;
    op(1'b0, 1'b1, 1'b0, 3, 16'h0000, 2'b00, 1'b1);
    op(1'b0, 1'b1, 1'b0, 0, 16'h0000, 2'b00, 1'b1);
    op(1'b0, 1'b1, 1'b0, 200, 16'h0000, 2'b00, 1'b1);
    op(1'b0, 1'b1, 1'b0, 511, 16'h0000, 2'b00, 1'b1);
  endtask

  task automatic test_out_of_range();
    op(1'b1, 1'b0, 1'b1, 499, 16'hAAAA, 2'b11, 1'b1);
    op(1'b1, 1'b0, 1'b1, 505, 16'h1234, 2'b11, 1'b1);
    op(1'b1, 1'b1, 1'b0, 499, 16'h0000, 2'b00, 1'b1);
    op(1'b1, 1'b1, 1'b0, 505, 16'h0000, 2'b00, 1'b1);
    op(1'b1, 1'b1, 1'b0, 500, 16'h0000, 2'b00, 1'b1);
    op(1'b1, 1'b1, 1'b0, 511, 16'h0000, 2'b00, 1'b1);
    op(1'b1, 1'b1, 1'b0, 499, 16'h0000, 2'b00, 1'b1);
  endtask

  task automatic test_reset_mid_clear();
    for (int k = 0; k < 251; k++) op(1'b1, 1'b0, 1'b1, k, k[15:0] ^ 16'h5A00, 2'b11, 1'b1);
    pulse_clear(1'b1);
    repeat (100) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    n_cmp++;
    if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: got busy=%b valid=%b, want busy=0 valid=0", busy_b, valid_b);
    end
    for (int k = 0; k < 100; k++) mdl_b[k] = 16'h0000;
    for (int k = 0; k < 100; k++) op(1'b1, 1'b1, 1'b0, k, 16'h0000, 2'b00, 1'b1);
    op(1'b1, 1'b1, 1'b0, 101, 16'h0000, 2'b00, 1'b1);
    op(1'b1, 1'b1, 1'b0, 200, 16'h0000, 2'b00, 1'b1);
    op(1'b1, 1'b1, 1'b0, 250, 16'h0000, 2'b00, 1'b1);
  endtask

  initial begin
    rst_a = 1'b1; read_a = 1'b0; write_a = 1'b0; clear_a = 1'b0;
    rst_b = 1'b1; read_b = 1'b0; write_b = 1'b0; clear_b = 1'b0;
    addr = 9'd0; data_in = 16'h0000; byte_en = 2'b00;
    test_reset();
    test_fill();
    test_byte_en();
    test_clear();
    test_out_of_range();
    test_reset_mid_clear();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
